// File: rtl/joy_db15_pkg.sv
// Shared constants for the DB15 adapter shift-chain emulation: word width,
// named button bit positions and the idle wire level.
package joy_db15_pkg;

    localparam int JOY_NBITS = 12;

    localparam int BIT_R = 0;
    localparam int BIT_L = 1;
    localparam int BIT_D = 2;
    localparam int BIT_U = 3;
    localparam int BIT_A = 4;
    localparam int BIT_B = 5;
    localparam int BIT_C = 6;
    localparam int BIT_X = 7;
    localparam int BIT_Y = 8;
    localparam int BIT_Z = 9;
    localparam int BIT_S = 10;
    localparam int BIT_M = 11;

    // Wire level of an unpressed button and of the fill after the frame.
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, followed by a
// history flop that yields single-cycle rise/fall strobes.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset loads the idle level into every flop so no edge is reported
    // while the chain refills after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Device side of the DB15 adapter chain: snapshots two joystick words while
// the host holds load low, then shifts them out active-low on joy_clk rises.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int NBITS       = JOY_NBITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [NBITS-1:0] joystick1,
    input  logic [NBITS-1:0] joystick2,
    input  logic             joy_load,
    input  logic             joy_clk,
    output logic             joy_data,
    output logic             frame_done,
    output logic             proto_err
);

    localparam int W  = 2 * NBITS;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic          load_level;
    logic          load_rise;
    logic          load_fall;
    logic          clk_level;
    logic          clk_rise;
    logic          clk_fall;
    logic          unused_sync;
    logic          load_active;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_load (
        .clk      (clk_sys),
        .reset    (reset),
        .async_in (joy_load),
        .level    (load_level),
        .rise     (load_rise),
        .fall     (load_fall)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_clk (
        .clk      (clk_sys),
        .reset    (reset),
        .async_in (joy_clk),
        .level    (clk_level),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    assign unused_sync = load_rise ^ load_fall ^ clk_level ^ clk_fall;
    assign load_active = ~load_level;

    // Load has priority: while it is active the chain stays transparent to
    // the live inputs and any host clock edge is reported as a protocol error.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shreg      <= {W{IDLE_LEVEL}};
            cnt        <= CNT_FULL;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
            if (load_active) begin
                shreg <= {~joystick2, ~joystick1};
                cnt   <= '0;
                if (clk_rise) begin
                    proto_err <= 1'b1;
                end
            end else if (clk_rise) begin
                shreg <= {IDLE_LEVEL, shreg[W-1:1]};
                if (cnt != CNT_FULL) begin
                    cnt <= cnt + 1'b1;
                end
                if (cnt == CNT_LAST) begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

    assign joy_data = shreg[0];

endmodule

// File: tb/tb_joy_db15_tx.sv
// Self-checking bench for joy_db15_tx: a behavioural host drives load/clock
// and compares the serial stream with the expected wire order.
module tb_joy_db15_tx;

    localparam int NB   = 12;
    localparam int W    = 2 * NB;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic          clk_sys;
    logic          reset;
    logic [NB-1:0] joystick1;
    logic [NB-1:0] joystick2;
    logic          joy_load;
    logic          joy_clk;
    logic          joy_data;
    logic          frame_done;
    logic          proto_err;

    int pass_cnt;
    int chk_cnt;
    int fd_total;
    int pe_total;

    logic [0:0] exp_q[$];

    joy_db15_tx #(
        .NBITS       (NB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .joy_load   (joy_load),
        .joy_clk    (joy_clk),
        .joy_data   (joy_data),
        .frame_done (frame_done),
        .proto_err  (proto_err)
    );

    // Clock and reset
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end

    // Pulse monitors: count every one-cycle strobe
    initial begin
        fd_total = 0;
        pe_total = 0;
    end

    always @(negedge clk_sys) begin
        if (frame_done === 1'b1) fd_total++;
        if (proto_err === 1'b1) pe_total++;
    end

    // Reference model: wire sequence of a frame plus idle fill
    task automatic model_frame(input logic [NB-1:0] j1, input logic [NB-1:0] j2, input int extra);
        exp_q.delete();
        for (int i = 0; i < NB; i++) exp_q.push_back(~j1[i]);
        for (int i = 0; i < NB; i++) exp_q.push_back(~j2[i]);
        for (int i = 0; i < extra; i++) exp_q.push_back(1'b1);
    endtask

    // Drivers
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic load_frame(input logic [NB-1:0] j1, input logic [NB-1:0] j2, input int hold);
        joystick1 = j1;
        joystick2 = j2;
        joy_load  = 1'b0;
        wait_cycles(hold);
        joy_load  = 1'b1;
        wait_cycles(SYNC + 3);
    endtask

    task automatic shift_edges(input int n, input int half, output logic [63:0] bits);
        bits = '1;
        for (int i = 0; i < n; i++) begin
            joy_clk = 1'b1;
            wait_cycles(half);
            bits[i] = joy_data;
            joy_clk = 1'b0;
            wait_cycles(half);
        end
    endtask

    // Tests
    task automatic test_reset();
        reset     = 1'b1;
        joy_load  = 1'b1;
        joy_clk   = 1'b0;
        joystick1 = '0;
        joystick2 = '0;
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(6);
        chk_cnt++;
        if (joy_data !== 1'b1) $display("FAIL reset_joy_data: got %b, required 1", joy_data);
        else pass_cnt++;
        chk_cnt++;
        if (fd_total !== 0 || pe_total !== 0)
            $display("FAIL reset_pulses: got fd=%0d pe=%0d, required 0/0", fd_total, pe_total);
        else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        logic [63:0] bits;
        logic [0:0]  exp;
        int fd0, pe0;
        model_frame(12'h001, 12'h000, 0);
        fd0 = fd_total;
        pe0 = pe_total;
        load_frame(12'h001, 12'h000, 10);
        exp = exp_q.pop_front();
        chk_cnt++;
        if (joy_data !== exp[0]) $display("FAIL basic_bit0: got %b, required %b", joy_data, exp[0]);
        else pass_cnt++;
        shift_edges(23, HALF, bits);
        for (int i = 0; i < 23; i++) begin
            exp = exp_q.pop_front();
            chk_cnt++;
            if (bits[i] !== exp[0]) $display("FAIL basic_bit%0d: got %b, required %b", i + 1, bits[i], exp[0]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (fd_total - fd0 !== 0) $display("FAIL basic_no_early_done: got %0d pulses, required 0", fd_total - fd0);
        else pass_cnt++;
        shift_edges(1, HALF, bits);
        chk_cnt++;
        if (bits[0] !== 1'b1) $display("FAIL basic_idle: got %b, required 1", bits[0]);
        else pass_cnt++;
        chk_cnt++;
        if (fd_total - fd0 !== 1) $display("FAIL basic_frame_done: got %0d pulses, required 1", fd_total - fd0);
        else pass_cnt++;
        chk_cnt++;
        if (pe_total - pe0 !== 0) $display("FAIL basic_proto_err: got %0d pulses, required 0", pe_total - pe0);
        else pass_cnt++;
    endtask

    task automatic test_p2_order();
        logic [63:0] bits;
        logic [0:0]  exp;
        int fd0;
        model_frame(12'h000, 12'h800, 3);
        fd0 = fd_total;
        load_frame(12'h000, 12'h800, 6);
        exp = exp_q.pop_front();
        chk_cnt++;
        if (joy_data !== exp[0]) $display("FAIL p2_bit0: got %b, required %b", joy_data, exp[0]);
        else pass_cnt++;
        shift_edges(26, HALF, bits);
        for (int i = 0; i < 26; i++) begin
            exp = exp_q.pop_front();
            chk_cnt++;
            if (bits[i] !== exp[0]) $display("FAIL p2_bit%0d: got %b, required %b", i + 1, bits[i], exp[0]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (fd_total - fd0 !== 1) $display("FAIL p2_single_done: got %0d pulses, required 1", fd_total - fd0);
        else pass_cnt++;
    endtask

    task automatic test_load_abort();
        logic [63:0]   bits;
        logic [0:0]    exp;
        logic [NB-1:0] j1, j2;
        int fd0;
        j1 = NB'($urandom_range(0, 4095));
        j2 = NB'($urandom_range(0, 4095));
        model_frame(j1, j2, 0);
        fd0 = fd_total;
        load_frame(j1, j2, 5);
        shift_edges(5, HALF, bits);
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (bits[i] !== exp_q[i + 1][0]) $display("FAIL abort_pre_bit%0d: got %b, required %b", i + 1, bits[i], exp_q[i + 1][0]);
            else pass_cnt++;
        end
        load_frame(j1, j2, 5);
        chk_cnt++;
        if (fd_total - fd0 !== 0) $display("FAIL abort_no_done: got %0d pulses, required 0", fd_total - fd0);
        else pass_cnt++;
        exp = exp_q.pop_front();
        chk_cnt++;
        if (joy_data !== exp[0]) $display("FAIL abort_bit0_again: got %b, required %b", joy_data, exp[0]);
        else pass_cnt++;
        shift_edges(24, HALF, bits);
        for (int i = 0; i < 23; i++) begin
            exp = exp_q.pop_front();
            chk_cnt++;
            if (bits[i] !== exp[0]) $display("FAIL abort_bit%0d: got %b, required %b", i + 1, bits[i], exp[0]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (fd_total - fd0 !== 1) $display("FAIL abort_restart_done: got %0d pulses, required 1", fd_total - fd0);
        else pass_cnt++;
    endtask

    task automatic test_clock_during_load();
        logic [63:0] bits;
        int pe0, fd0;
        pe0 = pe_total;
        fd0 = fd_total;
        joystick1 = 12'h0a5;
        joystick2 = 12'h35c;
        joy_load  = 1'b0;
        wait_cycles(SYNC + 3);
        shift_edges(3, HALF, bits);
        chk_cnt++;
        if (pe_total - pe0 !== 3) $display("FAIL load_proto_err: got %0d pulses, required 3", pe_total - pe0);
        else pass_cnt++;
        chk_cnt++;
        if (joy_data !== ~joystick1[0]) $display("FAIL load_track0: got %b, required %b", joy_data, ~joystick1[0]);
        else pass_cnt++;
        joystick1 = 12'h0a4;
        wait_cycles(3);
        chk_cnt++;
        if (joy_data !== ~joystick1[0]) $display("FAIL load_track1: got %b, required %b", joy_data, ~joystick1[0]);
        else pass_cnt++;
        joy_load = 1'b1;
        wait_cycles(SYNC + 3);
        chk_cnt++;
        if (fd_total - fd0 !== 0) $display("FAIL load_no_done: got %0d pulses, required 0", fd_total - fd0);
        else pass_cnt++;
        // Drain the frame so later tests start from a saturated count
        shift_edges(W, HALF, bits);
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] bits;
        int fd0;
        load_frame(12'h000, 12'h000, 6);
        shift_edges(7, HALF, bits);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        chk_cnt++;
        if (joy_data !== 1'b1) $display("FAIL rst_mid_data: got %b, required 1", joy_data);
        else pass_cnt++;
        @(negedge clk_sys);
        reset = 1'b0;
        fd0 = fd_total;
        shift_edges(20, HALF, bits);
        chk_cnt++;
        if (bits[19:0] !== 20'hfffff) $display("FAIL rst_mid_idle: got %h, required fffff", bits[19:0]);
        else pass_cnt++;
        chk_cnt++;
        if (fd_total - fd0 !== 0) $display("FAIL rst_mid_no_done: got %0d pulses, required 0", fd_total - fd0);
        else pass_cnt++;
    endtask

    task automatic test_loopback();
        logic [63:0]   bits;
        logic [NB-1:0] j1, j2, rx1, rx2;
        int fd0;
        for (int f = 0; f < 100; f++) begin
            j1  = NB'($urandom_range(0, 4095));
            j2  = NB'($urandom_range(0, 4095));
            fd0 = fd_total;
            load_frame(j1, j2, $urandom_range(3, 12));
            rx1[0] = ~joy_data;
            shift_edges(W, SYNC + 4, bits);
            for (int i = 1; i < NB; i++) rx1[i] = ~bits[i - 1];
            for (int i = 0; i < NB; i++) rx2[i] = ~bits[NB - 1 + i];
            chk_cnt++;
            if (rx1 !== j1) $display("FAIL loop_p1 frame %0d: got %h, required %h", f, rx1, j1);
            else pass_cnt++;
            chk_cnt++;
            if (rx2 !== j2) $display("FAIL loop_p2 frame %0d: got %h, required %h", f, rx2, j2);
            else pass_cnt++;
            chk_cnt++;
            if (fd_total - fd0 !== 1) $display("FAIL loop_done frame %0d: got %0d pulses, required 1", f, fd_total - fd0);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        test_reset();
        test_basic_frame();
        test_p2_order();
        test_load_abort();
        test_clock_during_load();
        test_reset_mid_frame();
        test_loopback();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
